// File: rtl/upper_layer_4_4_merge_rx_if.sv
// Signal bundle between the two lower-layer sorters, the merge receiver and its downstream consumer.
// The slave modport is the receiver's view; the master modport is the view of whatever surrounds it.
interface upper_layer_4_4_merge_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_update;
  logic                  a_done;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_update;
  logic                  b_done;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic                  err;

  modport master (
    output a_data, a_update, a_done, b_data, b_update, b_done, out_ready,
    input  out_data, out_valid, out_last, busy, err
  );

  modport slave (
    input  a_data, a_update, a_done, b_data, b_update, b_done, out_ready,
    output out_data, out_valid, out_last, busy, err
  );
endinterface

// File: rtl/upper_layer_4_4_merge_rx.sv
// Buffers two ascending serial streams (A, B) and re-emits them as a single ascending
// stream over a valid/ready handshake. Ties are resolved in favour of A.
module upper_layer_4_4_merge_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input logic                       clk,
  input logic                       rst,
  upper_layer_4_4_merge_rx_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {COLLECT, MERGE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] buf_a [DEPTH];
  logic [DATA_WIDTH-1:0] buf_b [DEPTH];
  logic [CW-1:0]         cnt_a, cnt_b, ia, ib;
  logic                  done_a, done_b;

  logic                  a_cap, b_cap, go, take_a, pick_a, at_end, is_last;
  logic [CW-1:0]         na, nb, ia_n, ib_n;
  logic [DATA_WIDTH-1:0] cur_a, cur_b, va, vb, sel;
  logic [CW:0]           total, pos_n;

  // Next pointers and the element that will be presented after this edge. While
  // collecting, an element captured this very cycle is forwarded from the input
  // so the first output can be registered on the transition into MERGE.
  always_comb begin
    a_cap  = (state == COLLECT) && bus.a_update && (cnt_a < FULL);
    b_cap  = (state == COLLECT) && bus.b_update && (cnt_b < FULL);
    na     = cnt_a + {{(CW-1){1'b0}}, a_cap};
    nb     = cnt_b + {{(CW-1){1'b0}}, b_cap};
    go     = (state == COLLECT) && (done_a || bus.a_done) && (done_b || bus.b_done);
    cur_a  = buf_a[ia[IW-1:0]];
    cur_b  = buf_b[ib[IW-1:0]];
    take_a = (ia < cnt_a) && ((ib >= cnt_b) || (cur_a <= cur_b));
    ia_n   = ia;
    ib_n   = ib;
    if (state == MERGE && bus.out_ready) begin
      if (take_a) ia_n = ia + 1'b1;
      else        ib_n = ib + 1'b1;
    end
    va      = (a_cap && ia_n == cnt_a) ? bus.a_data : buf_a[ia_n[IW-1:0]];
    vb      = (b_cap && ib_n == cnt_b) ? bus.b_data : buf_b[ib_n[IW-1:0]];
    pick_a  = (ia_n < na) && ((ib_n >= nb) || (va <= vb));
    sel     = pick_a ? va : vb;
    total   = {1'b0, na} + {1'b0, nb};
    pos_n   = {1'b0, ia_n} + {1'b0, ib_n};
    at_end  = (pos_n == total);
    is_last = (pos_n == total - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      cnt_a         <= '0;
      cnt_b         <= '0;
      ia            <= '0;
      ib            <= '0;
      done_a        <= 1'b0;
      done_b        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (a_cap) begin
            buf_a[cnt_a[IW-1:0]] <= bus.a_data;
            cnt_a                <= na;
          end
          if (b_cap) begin
            buf_b[cnt_b[IW-1:0]] <= bus.b_data;
            cnt_b                <= nb;
          end
          if (bus.a_update && !a_cap) bus.err <= 1'b1;
          if (bus.b_update && !b_cap) bus.err <= 1'b1;
          if (bus.a_done) done_a <= 1'b1;
          if (bus.b_done) done_b <= 1'b1;
          if (go) begin
            // Nothing captured on either side: flag it and wait for a fresh batch.
            if (total == '0) begin
              bus.err <= 1'b1;
              done_a  <= 1'b0;
              done_b  <= 1'b0;
            end else begin
              state         <= MERGE;
              bus.busy      <= 1'b1;
              bus.out_valid <= 1'b1;
              bus.out_data  <= sel;
              bus.out_last  <= (total == (CW+1)'(1));
              if (na != FULL || nb != FULL) bus.err <= 1'b1;
            end
          end
        end
        MERGE: begin
          if (bus.a_update || bus.a_done || bus.b_update || bus.b_done) bus.err <= 1'b1;
          if (bus.out_ready) begin
            if (at_end) begin
              state         <= COLLECT;
              cnt_a         <= '0;
              cnt_b         <= '0;
              ia            <= '0;
              ib            <= '0;
              done_a        <= 1'b0;
              done_b        <= 1'b0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.out_data  <= '0;
              bus.busy      <= 1'b0;
            end else begin
              ia           <= ia_n;
              ib           <= ib_n;
              bus.out_data <= sel;
              bus.out_last <= is_last;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule
